trigger_scaler_counter: RTL and testbench

TRIGGER_SCALER_COUNTER -- requirements
Module: trigger_scaler_counter

---
 rtl/trigger_scaler_counter_pkg.sv | 23 ++
 rtl/trigger_scaler_counter_channel.sv | 48 ++++
 rtl/trigger_scaler_counter.sv | 125 ++++++++++++
 tb/tb_trigger_scaler_counter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_scaler_counter_pkg.sv
// Shared trigger scaler definitions: channel layout, widths and read FSM states.
package trigger_scaler_counter_pkg;

   // Default channel count and counter width.
   localparam int TRIG_NCH  = 8;
   localparam int TRIG_CW   = 16;

   // Channel index ranges: low four are TDA inputs, upper four are reserved.
   localparam int TDA_FIRST = 0;
   localparam int TDA_LAST  = 3;
   localparam int RSV_FIRST = 4;
   localparam int RSV_LAST  = 7;

   // Read address width for the default channel count.
   localparam int TRIG_AW   = $clog2(TRIG_NCH);

   // Read handshake states.
   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_ACK  = 1'b1
   } rd_state_t;

endpackage

// File: rtl/trigger_scaler_counter_channel.sv
// One scaler channel: ce-qualified rising-edge detect, saturating counter
// and a sticky overflow bit, both cleared on the period latch.
module scaler_channel_counter #(
   parameter int CW = 16
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          ce_i,
   input  logic          scal_i,
   input  logic          clr_i,
   output logic [CW-1:0] cnt_o,
   output logic          ovf_o
);

   logic          r_scal;
   logic [CW-1:0] r_cnt;
   logic          r_ovf;
   logic          w_edge;
   logic          w_sat;

   // Edge is a 0->1 between consecutive ce-qualified samples; a long high counts once.
   assign w_edge = ce_i & scal_i & ~r_scal;
   assign w_sat  = (r_cnt == {CW{1'b1}});

   // Previous ce-qualified sample of the scaler input.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)  r_scal <= 1'b0;
      else if (ce_i) r_scal <= scal_i;
   end

   // Working count: clear on latch (an edge in that cycle starts the new period at 1), else saturating increment.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (clr_i) begin
         r_cnt <= w_edge ? CW'(1) : '0;
         r_ovf <= 1'b0;
      end else if (w_edge) begin
         if (w_sat) r_ovf <= 1'b1;
         else       r_cnt <= r_cnt + CW'(1);
      end
   end

   assign cnt_o = r_cnt;
   assign ovf_o = r_ovf;

endmodule

// File: rtl/trigger_scaler_counter.sv
// Trigger scaler counter top: NCH channel counters, period latch driven by
// the registered pps edge, holding registers and a one-cycle read handshake.
module trigger_scaler_counter
   import trigger_scaler_counter_pkg::*;
#(
   parameter int NCH = TRIG_NCH,
   parameter int CW  = TRIG_CW,
   parameter int AW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   input  logic           ce_i,
   input  logic [NCH-1:0] scal_i,
   input  logic           pps_i,
   input  logic           rd_req_i,
   input  logic [AW-1:0]  rd_addr_i,
   output logic           rd_ack_o,
   output logic [CW-1:0]  rd_data_o,
   output logic [NCH-1:0] ovf_o,
   output logic           update_o
);

   logic [CW-1:0]  w_cnt  [NCH];
   logic [NCH-1:0] w_ovf;
   logic [CW-1:0]  r_hold [NCH];
   logic           r_pps_s1;
   logic           r_pps_s2;
   logic           w_latch;
   logic           r_update;
   logic [NCH-1:0] r_ovf;
   rd_state_t      r_state;
   rd_state_t      w_state_next;
   logic           w_ack;
   logic [CW-1:0]  w_rd_sel;
   logic [CW-1:0]  r_rd_data;

   // Register pps twice; the latch cycle is the first cycle the registered value is high.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_pps_s1 <= 1'b0;
         r_pps_s2 <= 1'b0;
      end else begin
         r_pps_s1 <= pps_i;
         r_pps_s2 <= r_pps_s1;
      end
   end

   assign w_latch = r_pps_s1 & ~r_pps_s2;

   // Per-channel counters and their holding registers.
   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
         scaler_channel_counter #(
            .CW(CW)
         ) u_chan (
            .clk_i  (clk_i),
            .rst_n_i(rst_n_i),
            .ce_i   (ce_i),
            .scal_i (scal_i[gi]),
            .clr_i  (w_latch),
            .cnt_o  (w_cnt[gi]),
            .ovf_o  (w_ovf[gi])
         );

         // Holding register takes the finished period's count in the latch cycle.
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i)     r_hold[gi] <= '0;
            else if (w_latch) r_hold[gi] <= w_cnt[gi];
         end
      end
   endgenerate

   // Overflow flags and update pulse, both aligned with the new holding values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_ovf    <= '0;
         r_update <= 1'b0;
      end else begin
         if (w_latch) r_ovf <= w_ovf;
         r_update <= w_latch;
      end
   end

   // Read mux; addresses outside the channel range select zero.
   always_comb begin
      w_rd_sel = '0;
      for (int i = 0; i < NCH; i++) begin
         if (rd_addr_i == AW'(i)) w_rd_sel = r_hold[i];
      end
   end

   // Read data captured in the request cycle, so a read in the latch cycle sees the old value.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)      r_rd_data <= '0;
      else if (rd_req_i) r_rd_data <= w_rd_sel;
   end

   // Read FSM state register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_state <= RD_IDLE;
      else          r_state <= w_state_next;
   end

   // Read FSM next state and acknowledge decode.
   always_comb begin
      w_state_next = RD_IDLE;
      w_ack        = 1'b0;
      case (r_state)
         RD_IDLE: begin
            if (rd_req_i) w_state_next = RD_ACK;
         end
         RD_ACK: begin
            w_ack = 1'b1;
            if (rd_req_i) w_state_next = RD_ACK;
         end
         default: w_state_next = RD_IDLE;
      endcase
   end

   assign rd_ack_o  = w_ack;
   assign rd_data_o = r_rd_data;
   assign ovf_o     = r_ovf;
   assign update_o  = r_update;

endmodule

// File: tb/tb_trigger_scaler_counter.sv
// Directed bench for trigger_scaler_counter (CW=4 to reach saturation quickly,
// AW=4 so an out-of-range address can be driven).
module tb_trigger_scaler_counter;

   localparam int NCH = 8;
   localparam int CW  = 4;
   localparam int AW  = 4;

   logic           clk;
   logic           rst_n;
   logic           ce;
   logic [NCH-1:0] scal;
   logic           pps;
   logic           rd_req;
   logic [AW-1:0]  rd_addr;
   logic           rd_ack;
   logic [CW-1:0]  rd_data;
   logic [NCH-1:0] ovf;
   logic           update;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int ch;
      int npulse;
      int width;
      bit ce;
      int exp_cnt;
      bit exp_ovf;
   } vec_t;

   vec_t vecs[8];

   trigger_scaler_counter #(
      .NCH(NCH),
      .CW (CW),
      .AW (AW)
   ) dut (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .ce_i     (ce),
      .scal_i   (scal),
      .pps_i    (pps),
      .rd_req_i (rd_req),
      .rd_addr_i(rd_addr),
      .rd_ack_o (rd_ack),
      .rd_data_o(rd_data),
      .ovf_o    (ovf),
      .update_o (update)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic pulses(input int ch, input int n, input int w);
      for (int k = 0; k < n; k++) begin
         scal[ch] = 1'b1;
         repeat (w) tick();
         scal[ch] = 1'b0;
         tick();
      end
   endtask

   task automatic pps_period();
      pps = 1'b1;
      tick();
      tick();
      chk("update_pulse", 32'(update), 32'd1);
      pps = 1'b0;
      tick();
      chk("update_one_cycle", 32'(update), 32'd0);
   endtask

   task automatic do_read(input int addr, input int exp);
      rd_req  = 1'b1;
      rd_addr = AW'(addr);
      tick();
      chk("rd_ack", 32'(rd_ack), 32'd1);
      chk("rd_data", 32'(rd_data), 32'(exp));
      rd_req = 1'b0;
      tick();
      chk("rd_ack_drop", 32'(rd_ack), 32'd0);
      $display("[TB] read addr=%0d data=%0d expected=%0d", addr, rd_data, exp);
   endtask

   initial begin
      logic [31:0] e_ovf;

      //              ch  n  w  ce  cnt ovf
      vecs[0] = '{ch:0, npulse:5,  width:1,  ce:1'b1, exp_cnt:5,  exp_ovf:1'b0};
      vecs[1] = '{ch:3, npulse:1,  width:20, ce:1'b1, exp_cnt:1,  exp_ovf:1'b0};
      vecs[2] = '{ch:5, npulse:17, width:1,  ce:1'b1, exp_cnt:15, exp_ovf:1'b1};
      vecs[3] = '{ch:5, npulse:0,  width:1,  ce:1'b1, exp_cnt:0,  exp_ovf:1'b0};
      vecs[4] = '{ch:6, npulse:15, width:1,  ce:1'b1, exp_cnt:15, exp_ovf:1'b0};
      vecs[5] = '{ch:7, npulse:16, width:1,  ce:1'b1, exp_cnt:15, exp_ovf:1'b1};
      vecs[6] = '{ch:2, npulse:3,  width:2,  ce:1'b1, exp_cnt:3,  exp_ovf:1'b0};
      vecs[7] = '{ch:0, npulse:4,  width:1,  ce:1'b0, exp_cnt:0,  exp_ovf:1'b0};

      rst_n   = 1'b0;
      ce      = 1'b1;
      scal    = '0;
      pps     = 1'b0;
      rd_req  = 1'b0;
      rd_addr = '0;

      // Reset state
      tick();
      tick();
      chk("rst_rd_ack", 32'(rd_ack), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_update", 32'(update), 32'd0);
      rst_n = 1'b1;
      tick();

      // Table-driven periods: pulse one channel, close the period, read it back.
      for (int v = 0; v < 8; v++) begin
         ce = vecs[v].ce;
         pulses(vecs[v].ch, vecs[v].npulse, vecs[v].width);
         pps_period();
         ce = 1'b1;
         e_ovf = vecs[v].exp_ovf ? (32'd1 << vecs[v].ch) : 32'd0;
         chk("ovf_vec", 32'(ovf), e_ovf);
         do_read(vecs[v].ch, vecs[v].exp_cnt);
         $display("[TB] vec %0d ch=%0d edges=%0d ce=%0b ovf=%b", v, vecs[v].ch,
                  vecs[v].npulse, vecs[v].ce, ovf);
      end

      // Edge in the latch cycle belongs to the new period.
      pulses(2, 3, 1);
      pps = 1'b1;
      tick();
      scal[2] = 1'b1;
      tick();
      chk("latch_edge_update", 32'(update), 32'd1);
      scal[2] = 1'b0;
      pps     = 1'b0;
      tick();
      do_read(2, 3);
      pps_period();
      do_read(2, 1);

      // Read in the latch cycle returns the old value; re-read and sweep back-to-back.
      pulses(1, 7, 1);
      pps_period();
      pulses(1, 9, 1);
      pps = 1'b1;
      tick();
      rd_req  = 1'b1;
      rd_addr = 4'd1;
      tick();
      chk("latch_rd_ack", 32'(rd_ack), 32'd1);
      chk("latch_rd_old", 32'(rd_data), 32'd7);
      chk("latch_rd_update", 32'(update), 32'd1);
      pps = 1'b0;
      tick();
      chk("reread_ack", 32'(rd_ack), 32'd1);
      chk("reread_new", 32'(rd_data), 32'd9);
      for (int a = 0; a < NCH; a++) begin
         rd_addr = AW'(a);
         tick();
         chk("b2b_ack", 32'(rd_ack), 32'd1);
         chk("b2b_data", 32'(rd_data), (a == 1) ? 32'd9 : 32'd0);
         $display("[TB] b2b addr=%0d data=%0d ack=%0b", a, rd_data, rd_ack);
      end
      rd_addr = 4'd9;
      tick();
      chk("oor_ack", 32'(rd_ack), 32'd1);
      chk("oor_data", 32'(rd_data), 32'd0);
      rd_req = 1'b0;
      tick();
      chk("b2b_end_ack", 32'(rd_ack), 32'd0);
      do_read(1, 9);

      // Reset mid-period discards partial counts.
      pulses(4, 4, 1);
      pulses(7, 16, 1);
      rst_n = 1'b0;
      #2;
      chk("midrst_rd_data", 32'(rd_data), 32'd0);
      chk("midrst_ack", 32'(rd_ack), 32'd0);
      chk("midrst_ovf", 32'(ovf), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      pps_period();
      chk("postrst_ovf", 32'(ovf), 32'd0);
      for (int a = 0; a < NCH; a++) do_read(a, 0);
      do_read(9, 0);

      // Input high at reset release counts once.
      rst_n   = 1'b0;
      scal[3] = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      scal[3] = 1'b0;
      tick();
      pps_period();
      do_read(3, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
